// File: rtl/bcd_ctrl_pkg.sv
// Shared types and constants for the 2-digit BCD seconds counter controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package bcd_ctrl_pkg;

    // Run/stop state of the controller.
    typedef enum logic {
        S_STOPPED = 1'b0,
        S_RUNNING = 1'b1
    } ctrl_state_t;

    // Packed BCD byte: {tens, units}.
    typedef logic [7:0] bcd_t;

    // Highest count shown on the display (59 seconds).
    localparam bcd_t BCD_MAX_DEFAULT = 8'h59;

    // Width of the tick divider; wide enough for a 1 Hz tick from 50 MHz.
    localparam int DIV_W = 26;

    // True when both nibbles hold a decimal digit.
    function automatic logic is_bcd(input bcd_t v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_step.sv
// Computes the next BCD count one step up or down, wrapping 0..max; also flags legal values.
// Latency: combinational, zero cycles.
// Backpressure: none; purely combinational.
module bcd_step
    import bcd_ctrl_pkg::*;
(
    input  bcd_t value_i,
    input  logic up_i,
    input  bcd_t max_i,
    output bcd_t next_o,
    output logic is_valid_o
);

    logic [3:0] tens;
    logic [3:0] units;

    assign tens  = value_i[7:4];
    assign units = value_i[3:0];

    // Packed BCD orders the same way as binary, so a plain compare against max_i is exact.
    assign is_valid_o = is_bcd(value_i) && (value_i <= max_i);

    // Step with carry/borrow between digits; out-of-range inputs are forced back onto the wrap
    // points so the output is always a legal BCD value no greater than max_i.
    always_comb begin
        next_o = value_i;
        if (up_i) begin
            if (!is_valid_o || (value_i >= max_i)) begin
                next_o = 8'h00;
            end else if (units == 4'd9) begin
                next_o = {tens + 4'd1, 4'd0};
            end else begin
                next_o = {tens, units + 4'd1};
            end
        end else begin
            if (!is_valid_o || (value_i == 8'h00)) begin
                next_o = max_i;
            end else if (units == 4'd0) begin
                next_o = {tens - 4'd1, 4'd9};
            end else begin
                next_o = {tens, units - 4'd1};
            end
        end
    end

endmodule

// File: rtl/bcd_counter_controller.sv
// Run/stop, direction and load control for the 0..59 BCD seconds counter on HEX1/HEX0.
// Latency: commands take effect on the next clock edge; first tick TICK_PERIOD cycles after start.
// Backpressure: none; every command pulse is accepted in the cycle it arrives.
module bcd_counter_controller
    import bcd_ctrl_pkg::*;
#(
    parameter int   TICK_PERIOD = 50_000_000,
    parameter bcd_t BCD_MAX     = BCD_MAX_DEFAULT
) (
    input  logic       CLOCK_50_I,
    input  logic       resetn,
    input  logic       start_stop_pulse_i,
    input  logic       up_pulse_i,
    input  logic       down_pulse_i,
    input  logic       load_pulse_i,
    input  logic [7:0] load_value_i,
    output logic [7:0] count_o,
    output logic       running_o,
    output logic       up_o,
    output logic       tick_o,
    output logic       load_error_o
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_PERIOD - 1);

    ctrl_state_t       state;
    logic [DIV_W-1:0]  divider;
    logic              div_at_last;
    logic              step_due;
    bcd_t              step_in;
    bcd_t              step_next;
    logic              step_in_valid;

    // A load always pre-empts a step, so the shared helper can validate the load value
    // in those cycles and compute the next count in all others.
    assign step_in = load_pulse_i ? load_value_i : count_o;

    bcd_step u_step (
        .value_i    (step_in),
        .up_i       (up_o),
        .max_i      (BCD_MAX),
        .next_o     (step_next),
        .is_valid_o (step_in_valid)
    );

    assign div_at_last = (divider == DIV_LAST);

    // A stop request landing on the tick cycle cancels that tick entirely.
    assign step_due = (state == S_RUNNING) && div_at_last && !start_stop_pulse_i;

    // Run/stop FSM; running_o is registered alongside the state it mirrors.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state     <= S_STOPPED;
            running_o <= 1'b0;
        end else if (start_stop_pulse_i) begin
            case (state)
                S_STOPPED: begin
                    state     <= S_RUNNING;
                    running_o <= 1'b1;
                end
                S_RUNNING: begin
                    state     <= S_STOPPED;
                    running_o <= 1'b0;
                end
                default: begin
                    state     <= S_STOPPED;
                    running_o <= 1'b0;
                end
            endcase
        end
    end

    // Tick divider: free-runs while running, parked at 0 while stopped and on any run/stop toggle.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            divider <= '0;
        end else if ((state == S_RUNNING) && !start_stop_pulse_i) begin
            divider <= div_at_last ? '0 : divider + DIV_W'(1);
        end else begin
            divider <= '0;
        end
    end

    // One-cycle tick pulse, coincident with the count step it announces.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            tick_o <= 1'b0;
        end else begin
            tick_o <= step_due;
        end
    end

    // Count register: a load (valid or not) takes priority over the step.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            count_o      <= 8'h00;
            load_error_o <= 1'b0;
        end else begin
            load_error_o <= load_pulse_i && !step_in_valid;
            if (load_pulse_i) begin
                if (step_in_valid) begin
                    count_o <= load_value_i;
                end
            end else if (step_due) begin
                count_o <= step_next;
            end
        end
    end

    // Direction register; conflicting up/down pulses cancel and leave it unchanged.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            up_o <= 1'b1;
        end else if (up_pulse_i && !down_pulse_i) begin
            up_o <= 1'b1;
        end else if (down_pulse_i && !up_pulse_i) begin
            up_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_counter_controller.sv
// Self-checking bench: directed scenarios plus random command traffic against a decimal model.
// Latency: model expects commands to act on the edge that samples them.
// Backpressure: none; stimulus drives one command set per cycle.
module tb_bcd_counter_controller;

    localparam int TP = 10;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ss = 1'b0;
    logic       upp = 1'b0;
    logic       dnp = 1'b0;
    logic       ldp = 1'b0;
    logic [7:0] ldv = 8'h00;
    logic [7:0] count_o;
    logic       running_o;
    logic       up_o;
    logic       tick_o;
    logic       load_error_o;

    int checks = 0;
    int errors = 0;

    // Model state: count kept as a plain decimal 0..59.
    int m_cnt;
    bit m_run;
    bit m_up;
    bit m_tick;
    bit m_err;
    int since;

    bcd_counter_controller #(.TICK_PERIOD(TP), .BCD_MAX(8'h59)) dut (
        .CLOCK_50_I         (clk),
        .resetn             (resetn),
        .start_stop_pulse_i (ss),
        .up_pulse_i         (upp),
        .down_pulse_i       (dnp),
        .load_pulse_i       (ldp),
        .load_value_i       (ldv),
        .count_o            (count_o),
        .running_o          (running_o),
        .up_o               (up_o),
        .tick_o             (tick_o),
        .load_error_o       (load_error_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_run = 0; m_up = 1; m_tick = 0; m_err = 0; since = 0;
    endtask

    // One clock edge of the model: ticks fall every TP edges after the start edge.
    task automatic model_edge(input bit s, input bit u, input bit d, input bit l, input logic [7:0] v);
        bit due;
        int tens;
        int units;
        due = 0;
        m_err = 0;
        if (m_run) begin
            since++;
            if (since == TP) begin
                due = 1;
                since = 0;
            end
        end
        if (s) begin
            if (m_run) begin
                m_run = 0;
                due = 0;
            end else begin
                m_run = 1;
                since = 0;
            end
        end
        m_tick = due;
        tens  = int'(v[7:4]);
        units = int'(v[3:0]);
        if (l) begin
            if (tens <= 9 && units <= 9 && (tens * 10 + units) <= 59) m_cnt = tens * 10 + units;
            else m_err = 1;
        end else if (due) begin
            m_cnt = m_up ? (m_cnt + 1) % 60 : (m_cnt + 59) % 60;
        end
        if (u && !d) m_up = 1;
        else if (d && !u) m_up = 0;
    endtask

    task automatic compare_all();
        chk("count", count_o, to_bcd(m_cnt));
        chk("running", 8'(running_o), 8'(m_run));
        chk("up", 8'(up_o), 8'(m_up));
        chk("tick", 8'(tick_o), 8'(m_tick));
        chk("load_error", 8'(load_error_o), 8'(m_err));
    endtask

    // Drive one cycle of commands, advance the model on the edge, compare after it.
    task automatic cycle(input bit s, input bit u, input bit d, input bit l, input logic [7:0] v);
        @(negedge clk);
        ss = s; upp = u; dnp = d; ldp = l; ldv = v;
        @(posedge clk);
        model_edge(s, u, d, l, v);
        #1;
        compare_all();
        ss = 0; upp = 0; dnp = 0; ldp = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 8'h00);
    endtask

    // Run n idle cycles after a start and pin count/tick on every TP-th cycle.
    task automatic run_ticks(input string name, input int n, input logic [7:0] e0, input logic [7:0] e1);
        for (int i = 1; i <= n; i++) begin
            cycle(0, 0, 0, 0, 8'h00);
            if (i == TP) begin
                chk({name, "_tick1"}, 8'(tick_o), 8'h01);
                chk({name, "_cnt1"}, count_o, e0);
            end
            if (i == 2 * TP) begin
                chk({name, "_tick2"}, 8'(tick_o), 8'h01);
                chk({name, "_cnt2"}, count_o, e1);
            end
        end
    endtask

    initial begin
        logic [7:0] exp1 [3];
        exp1 = '{8'h01, 8'h02, 8'h03};
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", count_o, 8'h00);
        chk("rst_running", 8'(running_o), 8'h00);
        chk("rst_up", 8'(up_o), 8'h01);
        chk("rst_tick", 8'(tick_o), 8'h00);
        chk("rst_err", 8'(load_error_o), 8'h00);
        @(negedge clk);
        resetn = 1;

        // 1: start, ticks at 10/20/30
        cycle(1, 0, 0, 0, 8'h00);
        for (int i = 1; i <= 30; i++) begin
            cycle(0, 0, 0, 0, 8'h00);
            if (i % TP == 0) begin
                chk("t1_tick", 8'(tick_o), 8'h01);
                chk("t1_cnt", count_o, exp1[i / TP - 1]);
                chk("t1_model", to_bcd(m_cnt), exp1[i / TP - 1]);
            end
        end
        cycle(1, 0, 0, 0, 8'h00);

        // 2: wrap up and wrap down
        cycle(0, 0, 0, 1, 8'h58);
        cycle(0, 1, 0, 0, 8'h00);
        cycle(1, 0, 0, 0, 8'h00);
        run_ticks("t2up", 2 * TP, 8'h59, 8'h00);
        cycle(1, 0, 0, 0, 8'h00);
        cycle(0, 0, 0, 1, 8'h01);
        cycle(0, 0, 1, 0, 8'h00);
        cycle(1, 0, 0, 0, 8'h00);
        run_ticks("t2dn", 2 * TP, 8'h00, 8'h59);
        chk("t2_model", to_bcd(m_cnt), 8'h59);
        cycle(1, 0, 0, 0, 8'h00);

        // 3: load on the tick cycle wins over the step
        cycle(0, 1, 0, 0, 8'h00);
        cycle(1, 0, 0, 0, 8'h00);
        idle(TP - 1);
        cycle(0, 0, 0, 1, 8'h33);
        chk("t3_cnt", count_o, 8'h33);
        chk("t3_tick", 8'(tick_o), 8'h01);
        idle(TP);
        chk("t3_next", count_o, 8'h34);
        cycle(1, 0, 0, 0, 8'h00);

        // 4: rejected loads
        cycle(0, 0, 0, 1, 8'h4A);
        chk("t4_err_a", 8'(load_error_o), 8'h01);
        chk("t4_cnt_a", count_o, 8'h34);
        idle(1);
        chk("t4_err_clr", 8'(load_error_o), 8'h00);
        cycle(0, 0, 0, 1, 8'h60);
        chk("t4_err_b", 8'(load_error_o), 8'h01);
        chk("t4_cnt_b", count_o, 8'h34);

        // 5: direction control
        cycle(0, 1, 1, 0, 8'h00);
        chk("t5_both_up", 8'(up_o), 8'h01);
        cycle(0, 0, 1, 0, 8'h00);
        chk("t5_down", 8'(up_o), 8'h00);
        cycle(0, 1, 1, 0, 8'h00);
        chk("t5_both_dn", 8'(up_o), 8'h00);
        idle(15);
        chk("t5_cnt", count_o, 8'h34);

        // 6: async reset mid-period, then a clean restart
        cycle(0, 0, 0, 1, 8'h27);
        cycle(0, 1, 0, 0, 8'h00);
        cycle(1, 0, 0, 0, 8'h00);
        idle(5);
        @(negedge clk);
        #2 resetn = 0;
        #1;
        chk("t6_count", count_o, 8'h00);
        chk("t6_running", 8'(running_o), 8'h00);
        chk("t6_up", 8'(up_o), 8'h01);
        chk("t6_tick", 8'(tick_o), 8'h00);
        model_reset();
        @(negedge clk);
        resetn = 1;
        cycle(1, 0, 0, 0, 8'h00);
        run_ticks("t6", TP, 8'h01, 8'h00);

        // Random command traffic
        for (int n = 0; n < 3000; n++) begin
            bit s;
            bit u;
            bit d;
            bit l;
            logic [7:0] v;
            s = ($urandom_range(39) == 0);
            u = ($urandom_range(14) == 0);
            d = ($urandom_range(14) == 0);
            l = ($urandom_range(19) == 0);
            if ($urandom_range(1) == 0) v = 8'($urandom_range(255));
            else v = to_bcd(int'($urandom_range(59)));
            cycle(s, u, d, l, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
